counter_ctrl: RTL and testbench

COUNTER_CTRL -- requirements
Module: counter_ctrl

---
 rtl/counter_ctrl_if.sv | 32 +++
 rtl/counter_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_ctrl_if.sv
// Command, control and status bundle for counter_ctrl.
// master = command source / status observer, slave = counter_ctrl itself.
interface counter_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_limit;
  logic             cmd_up;
  logic             cmd_periodic;
  logic [PRE_W-1:0] cmd_prescale;
  logic             pause;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output cmd_valid, cmd_start, cmd_limit, cmd_up, cmd_periodic, cmd_prescale,
    output pause, abort,
    input  cmd_ready, count, busy, tc, done
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_limit, cmd_up, cmd_periodic, cmd_prescale,
    input  pause, abort,
    output cmd_ready, count, busy, tc, done
  );
endinterface

// File: rtl/counter_ctrl.sv
// Prescaled up/down counter with one-shot/periodic modes, pause and abort.
// Commands accepted only in IDLE; count, tc and done are registered.
module counter_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 8
) (
  input logic           clk,
  input logic           rst,
  counter_ctrl_if.slave ctrl_if
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             up_q, up_d;
  logic             periodic_q, periodic_d;
  logic [PRE_W-1:0] prescale_q, prescale_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             step;

  assign step = (pre_cnt_q == prescale_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    start_d    = start_q;
    limit_d    = limit_q;
    up_d       = up_q;
    periodic_d = periodic_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    tc_d       = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ctrl_if.cmd_valid) begin
          start_d    = ctrl_if.cmd_start;
          limit_d    = ctrl_if.cmd_limit;
          up_d       = ctrl_if.cmd_up;
          periodic_d = ctrl_if.cmd_periodic;
          prescale_d = ctrl_if.cmd_prescale;
          count_d    = ctrl_if.cmd_start;
          pre_cnt_d  = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        // abort beats pause beats step
        if (ctrl_if.abort) begin
          state_d = IDLE;
        end else if (ctrl_if.pause) begin
          state_d = PAUSED;
        end else if (!step) begin
          pre_cnt_d = pre_cnt_q + PRE_ONE;
        end else begin
          pre_cnt_d = '0;
          if (count_q != limit_q) begin
            count_d = up_q ? count_q + CNT_ONE : count_q - CNT_ONE;
          end else if (periodic_q) begin
            count_d = start_q;
            tc_d    = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (ctrl_if.abort) begin
          state_d = IDLE;
        end else if (!ctrl_if.pause) begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      start_q    <= '0;
      limit_q    <= '0;
      up_q       <= 1'b0;
      periodic_q <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      tc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      start_q    <= start_d;
      limit_q    <= limit_d;
      up_q       <= up_d;
      periodic_q <= periodic_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      tc_q       <= tc_d;
      done_q     <= done_d;
    end
  end

  assign ctrl_if.cmd_ready = (state_q == IDLE) && rst;
  assign ctrl_if.count     = count_q;
  assign ctrl_if.busy      = (state_q == RUN) || (state_q == PAUSED);
  assign ctrl_if.tc        = tc_q;
  assign ctrl_if.done      = done_q;
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: per-cycle comparison against a cycle model
// plus hand-computed literal expectations at key points of each scenario.
module tb_counter_ctrl;
  localparam int WIDTH = 4;
  localparam int PRE_W = 8;
  localparam int MOD   = 1 << WIDTH;

  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_PAUSED = 2;
  localparam int M_DONE   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_en  = 1'b0;

  counter_ctrl_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

  counter_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: integer count arithmetic modulo 2^WIDTH
  int m_state = M_IDLE;
  int m_count = 0, m_pre = 0;
  int m_start = 0, m_lim = 0, m_up = 0, m_per = 0, m_ps = 0;
  int m_tc = 0, m_done = 0;

  always @(posedge clk) begin
    m_tc   = 0;
    m_done = 0;
    if (!rst) begin
      m_state = M_IDLE;
      m_count = 0; m_pre = 0;
      m_start = 0; m_lim = 0; m_up = 0; m_per = 0; m_ps = 0;
    end else begin
      case (m_state)
        M_IDLE: if (bus.cmd_valid) begin
          m_start = int'(bus.cmd_start);
          m_lim   = int'(bus.cmd_limit);
          m_up    = int'(bus.cmd_up);
          m_per   = int'(bus.cmd_periodic);
          m_ps    = int'(bus.cmd_prescale);
          m_count = m_start;
          m_pre   = 0;
          m_state = M_RUN;
        end
        M_RUN: begin
          if (bus.abort) m_state = M_IDLE;
          else if (bus.pause) m_state = M_PAUSED;
          else if (m_pre < m_ps) m_pre = m_pre + 1;
          else begin
            m_pre = 0;
            if (m_count != m_lim) m_count = (m_count + (m_up != 0 ? 1 : MOD - 1)) % MOD;
            else if (m_per != 0) begin m_count = m_start; m_tc = 1; end
            else begin m_state = M_DONE; m_done = 1; end
          end
        end
        M_PAUSED: begin
          if (bus.abort) m_state = M_IDLE;
          else if (!bus.pause) m_state = M_RUN;
        end
        default: m_state = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", 32'(bus.count), 32'(m_count));
      chk("model_busy",  32'(bus.busy),  32'(m_state == M_RUN || m_state == M_PAUSED));
      chk("model_tc",    32'(bus.tc),    32'(m_tc));
      chk("model_done",  32'(bus.done),  32'(m_done));
      chk("model_ready", 32'(bus.cmd_ready), 32'(m_state == M_IDLE && rst));
    end
  end

  task automatic pin(input string nm, input int c, input int b, input int d, input int t);
    chk({nm, "_count"}, 32'(bus.count), 32'(c));
    chk({nm, "_busy"},  32'(bus.busy),  32'(b));
    chk({nm, "_done"},  32'(bus.done),  32'(d));
    chk({nm, "_tc"},    32'(bus.tc),    32'(t));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Presents one command for one edge, then scrambles the fields so that
  // any use of unlatched inputs during the run shows up.
  task automatic send(input int s, input int l, input int u, input int p, input int ps);
    bus.cmd_valid    = 1'b1;
    bus.cmd_start    = WIDTH'(s);
    bus.cmd_limit    = WIDTH'(l);
    bus.cmd_up       = 1'(u);
    bus.cmd_periodic = 1'(p);
    bus.cmd_prescale = PRE_W'(ps);
    cyc(1);
    bus.cmd_valid    = 1'b0;
    bus.cmd_start    = ~bus.cmd_start;
    bus.cmd_limit    = ~bus.cmd_limit;
    bus.cmd_up       = ~bus.cmd_up;
    bus.cmd_periodic = ~bus.cmd_periodic;
    bus.cmd_prescale = ~bus.cmd_prescale;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seq [4];
    seq = '{1, 0, 15, 14};
    bus.cmd_valid = 1'b0; bus.cmd_start = '0; bus.cmd_limit = '0;
    bus.cmd_up = 1'b0; bus.cmd_periodic = 1'b0; bus.cmd_prescale = '0;
    bus.pause = 1'b0; bus.abort = 1'b0;

    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    pin("reset", 0, 0, 0, 0);
    chk("reset_ready", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("ready_after_reset", 32'(bus.cmd_ready), 32'd1);

    // One-shot up 3 -> 6, prescale 0
    send(3, 6, 1, 0, 0);
    pin("os_k0", 3, 1, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      pin("os_run", 3 + k, 1, 0, 0);
    end
    cyc(1);
    pin("os_done", 6, 0, 1, 0);
    cyc(1);
    pin("os_after", 6, 0, 0, 0);
    chk("os_ready", 32'(bus.cmd_ready), 32'd1);

    // Periodic down 1 -> 14 with wrap 0 -> 15, prescale 1, then abort
    send(1, 14, 0, 1, 1);
    for (int k = 0; k < 18; k++) begin
      if (k > 0) cyc(1);
      pin("per", seq[(k / 2) % 4], 1, 0, (k > 0 && k % 8 == 0) ? 1 : 0);
    end
    bus.abort = 1'b1;
    cyc(1);
    bus.abort = 1'b0;
    pin("per_abort", 1, 0, 0, 0);

    // Start equal to limit, prescale 2
    send(9, 9, 1, 0, 2);
    pin("eq_k0", 9, 1, 0, 0);
    cyc(1); pin("eq_k1", 9, 1, 0, 0);
    cyc(1); pin("eq_k2", 9, 1, 0, 0);
    cyc(1); pin("eq_done", 9, 0, 1, 0);
    cyc(1); pin("eq_after", 9, 0, 0, 0);

    // Pause four cycles mid-prescale, then abort together with pause
    send(2, 8, 1, 0, 1);
    pin("pz_k0", 2, 1, 0, 0);
    cyc(1); pin("pz_k1", 2, 1, 0, 0);
    cyc(1); pin("pz_k2", 3, 1, 0, 0);
    cyc(1); pin("pz_k3", 3, 1, 0, 0);
    bus.pause = 1'b1;
    cyc(4); pin("pz_held", 3, 1, 0, 0);
    bus.pause = 1'b0;
    cyc(1); pin("pz_resume", 3, 1, 0, 0);
    cyc(1); pin("pz_step", 4, 1, 0, 0);
    cyc(1); pin("pz_k10", 4, 1, 0, 0);
    bus.pause = 1'b1;
    bus.abort = 1'b1;
    cyc(1); pin("pz_abort", 4, 0, 0, 0);
    bus.pause = 1'b0;
    bus.abort = 1'b0;

    // Hold-off: new command held while busy, accepted after the done cycle
    send(0, 2, 1, 0, 0);
    pin("ho_k0", 0, 1, 0, 0);
    bus.cmd_valid = 1'b1; bus.cmd_start = 4'd5; bus.cmd_limit = 4'd7;
    bus.cmd_up = 1'b1; bus.cmd_periodic = 1'b0; bus.cmd_prescale = '0;
    cyc(1); pin("ho_k1", 1, 1, 0, 0); chk("ho_rdy1", 32'(bus.cmd_ready), 32'd0);
    cyc(1); pin("ho_k2", 2, 1, 0, 0); chk("ho_rdy2", 32'(bus.cmd_ready), 32'd0);
    cyc(1); pin("ho_done", 2, 0, 1, 0); chk("ho_rdy3", 32'(bus.cmd_ready), 32'd0);
    bus.abort = 1'b1;
    cyc(1); pin("ho_idle", 2, 0, 0, 0); chk("ho_rdy4", 32'(bus.cmd_ready), 32'd1);
    cyc(1); pin("ho_accept", 5, 1, 0, 0);
    bus.cmd_valid = 1'b0;
    bus.abort = 1'b0;
    cyc(1); pin("ho_r6", 6, 1, 0, 0);
    cyc(1); pin("ho_r7", 7, 1, 0, 0);
    cyc(1); pin("ho_done2", 7, 0, 1, 0);
    cyc(1);

    // Periodic up wrapping 15 -> 0, reset mid-run
    send(14, 1, 1, 1, 0);
    pin("rs_k0", 14, 1, 0, 0);
    cyc(1); pin("rs_k1", 15, 1, 0, 0);
    cyc(1); pin("rs_k2", 0, 1, 0, 0);
    cyc(1); pin("rs_k3", 1, 1, 0, 0);
    rst = 1'b0;
    cyc(2);
    pin("rs_reset", 0, 0, 0, 0);
    chk("rs_ready_low", 32'(bus.cmd_ready), 32'd0);
    rst = 1'b1;
    cyc(1);
    chk("rs_ready_high", 32'(bus.cmd_ready), 32'd1);
    pin("rs_idle", 0, 0, 0, 0);

    // Fresh command after reset, start equal to limit, prescale 0
    send(5, 5, 1, 0, 0);
    pin("fr_k0", 5, 1, 0, 0);
    cyc(1); pin("fr_done", 5, 0, 1, 0);
    cyc(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
